regfile: RTL and testbench



---
 rtl/regfile.sv | 99 +++++++++
 tb/tb_regfile.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// 32-entry RV32I integer register file: one write port, zero-latency read ports with write-through bypass.
// Optional REGFILE_DEBUG_PORT_EN adds an always-enabled debug read port and a committed-write counter.
module regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              reg_wena_i,
  input  logic [ADDR_W-1:0] reg_waddr_i,
  input  logic [DATA_W-1:0] reg_wdata_i,
  input  logic              rs1_rena_i,
  input  logic [ADDR_W-1:0] rs1_raddr_i,
  output logic [DATA_W-1:0] rs1_rdata_o,
  input  logic              rs2_rena_i,
  input  logic [ADDR_W-1:0] rs2_raddr_i,
`ifdef REGFILE_DEBUG_PORT_EN
  output logic [DATA_W-1:0] rs2_rdata_o,
  input  logic [ADDR_W-1:0] dbg_raddr_i,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic [31:0]       dbg_wcnt_o
`else
  output logic [DATA_W-1:0] rs2_rdata_o
`endif
);

`ifdef REGFILE_DEBUG_PORT_EN
  localparam int NUM_RD = 3;
`else
  localparam int NUM_RD = 2;
`endif

  logic [DATA_W-1:0] regs_reg   [1:NUM_REGS-1];
  logic [DATA_W-1:0] entry_view [NUM_REGS];
  logic [NUM_REGS-1:1] wsel;

  logic              rd_en   [NUM_RD];
  logic [ADDR_W-1:0] rd_addr [NUM_RD];
  logic [DATA_W-1:0] rd_data [NUM_RD];

  // x0 has no flop; it is a hard-wired zero in the read view.
  assign entry_view[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_entry
      assign wsel[gi]       = reg_wena_i && (reg_waddr_i == ADDR_W'(gi));
      assign entry_view[gi] = regs_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 1; i < NUM_REGS; i++) regs_reg[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wsel[i]) regs_reg[i] <= reg_wdata_i;
      end
    end
  end

  assign rd_en[0]   = rs1_rena_i;
  assign rd_addr[0] = rs1_raddr_i;
  assign rd_en[1]   = rs2_rena_i;
  assign rd_addr[1] = rs2_raddr_i;

  // Priority: reset, enable, x0, same-cycle bypass, stored value.
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      assign rd_data[gi] =
          (!arst_n || !rd_en[gi] || (rd_addr[gi] == '0)) ? '0 :
          (reg_wena_i && (rd_addr[gi] == reg_waddr_i))   ? reg_wdata_i :
                                                           entry_view[rd_addr[gi]];
    end
  endgenerate

  assign rs1_rdata_o = rd_data[0];
  assign rs2_rdata_o = rd_data[1];

`ifdef REGFILE_DEBUG_PORT_EN
  logic [31:0] wcnt_reg;

  assign rd_en[2]    = 1'b1;
  assign rd_addr[2]  = dbg_raddr_i;
  assign dbg_rdata_o = rd_data[2];
  assign dbg_wcnt_o  = wcnt_reg;

  // Counts only writes that reach storage; wraps naturally at 2**32.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wcnt_reg <= '0;
    end else if (reg_wena_i && (reg_waddr_i != '0)) begin
      wcnt_reg <= wcnt_reg + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: expected read values are queued as stimulus is driven and checked once outputs settle.
module tb_regfile;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              arst_n;
  logic              reg_wena_i;
  logic [ADDR_W-1:0] reg_waddr_i;
  logic [DATA_W-1:0] reg_wdata_i;
  logic              rs1_rena_i;
  logic [ADDR_W-1:0] rs1_raddr_i;
  logic [DATA_W-1:0] rs1_rdata_o;
  logic              rs2_rena_i;
  logic [ADDR_W-1:0] rs2_raddr_i;
  logic [DATA_W-1:0] rs2_rdata_o;
`ifdef REGFILE_DEBUG_PORT_EN
  logic [ADDR_W-1:0] dbg_raddr_i;
  logic [DATA_W-1:0] dbg_rdata_o;
  logic [31:0]       dbg_wcnt_o;
`endif

  regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(32)) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .reg_wena_i  (reg_wena_i),
    .reg_waddr_i (reg_waddr_i),
    .reg_wdata_i (reg_wdata_i),
    .rs1_rena_i  (rs1_rena_i),
    .rs1_raddr_i (rs1_raddr_i),
    .rs1_rdata_o (rs1_rdata_o),
    .rs2_rena_i  (rs2_rena_i),
    .rs2_raddr_i (rs2_raddr_i),
`ifdef REGFILE_DEBUG_PORT_EN
    .rs2_rdata_o (rs2_rdata_o),
    .dbg_raddr_i (dbg_raddr_i),
    .dbg_rdata_o (dbg_rdata_o),
    .dbg_wcnt_o  (dbg_wcnt_o)
`else
    .rs2_rdata_o (rs2_rdata_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          port;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t    sb_q[$];
  logic [31:0] model [32];
  int          checks = 0;
  int          errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // port: 0 = rs1, 1 = rs2, 2 = debug read, 3 = debug write counter
  task automatic expect_rd(input string tag, input int port, input logic [31:0] exp);
    sb_item_t it;
    it.tag  = tag;
    it.port = port;
    it.exp  = exp;
    sb_q.push_back(it);
  endtask

  task automatic sample_all();
    sb_item_t    it;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      case (it.port)
        0:       obs = rs1_rdata_o;
        1:       obs = rs2_rdata_o;
`ifdef REGFILE_DEBUG_PORT_EN
        2:       obs = dbg_rdata_o;
        3:       obs = dbg_wcnt_o;
`endif
        default: obs = 32'hxxxx_xxxx;
      endcase
      check_val(it.tag, obs, it.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
    sample_all();
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    reg_wena_i  = 1'b1;
    reg_waddr_i = a;
    reg_wdata_i = d;
    tick();
    reg_wena_i = 1'b0;
    if (a != 5'd0) model[a] = d;
    $display("WR x%0d <= %08h", a, d);
  endtask

  task automatic read_pair(input string tag, input logic [4:0] a1, input logic [4:0] a2);
    rs1_raddr_i = a1;
    rs2_raddr_i = a2;
    expect_rd(tag, 0, model[a1]);
    expect_rd(tag, 1, model[a2]);
    settle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;
    arst_n      = 1'b0;
    reg_wena_i  = 1'b0;
    reg_waddr_i = '0;
    reg_wdata_i = '0;
    rs1_rena_i  = 1'b1;
    rs1_raddr_i = 5'd5;
    rs2_rena_i  = 1'b1;
    rs2_raddr_i = 5'd3;
`ifdef REGFILE_DEBUG_PORT_EN
    dbg_raddr_i = 5'd5;
`endif

    // Reset held: outputs forced to zero, even with a pending write to the read address.
    #2;
    reg_wena_i  = 1'b1;
    reg_waddr_i = 5'd5;
    reg_wdata_i = 32'hCAFE_F00D;
    expect_rd("rst_rs1", 0, 32'h0);
    expect_rd("rst_rs2", 1, 32'h0);
`ifdef REGFILE_DEBUG_PORT_EN
    expect_rd("rst_dbg", 2, 32'h0);
    expect_rd("rst_wcnt", 3, 32'h0);
`endif
    settle();
    repeat (2) tick();
    reg_wena_i = 1'b0;
    #2 arst_n = 1'b1;
    #1;

    // All entries zero after release; x5 write during reset must not have landed.
    for (int a = 0; a < 32; a++) read_pair("rst_sweep", 5'(a), 5'(31 - a));
`ifdef REGFILE_DEBUG_PORT_EN
    expect_rd("wcnt_after_rst", 3, 32'd0);
    settle();
`endif
    tick();

    do_write(5'd3, 32'hDEAD_BEEF);
    read_pair("wr_rd_x3", 5'd3, 5'd3);

    // Same-cycle bypass on both ports, then the stored value after the edge.
    do_write(5'd7, 32'h1111_1111);
    reg_wena_i  = 1'b1;
    reg_waddr_i = 5'd7;
    reg_wdata_i = 32'h2222_2222;
    rs1_raddr_i = 5'd7;
    rs2_raddr_i = 5'd7;
    expect_rd("bypass_rs1", 0, 32'h2222_2222);
    expect_rd("bypass_rs2", 1, 32'h2222_2222);
`ifdef REGFILE_DEBUG_PORT_EN
    dbg_raddr_i = 5'd7;
    expect_rd("bypass_dbg", 2, 32'h2222_2222);
`endif
    settle();
    tick();
    reg_wena_i = 1'b0;
    model[7] = 32'h2222_2222;
    read_pair("bypass_stored", 5'd7, 5'd7);

    // Pending write to a third register must not disturb unrelated reads.
    reg_wena_i  = 1'b1;
    reg_waddr_i = 5'd12;
    reg_wdata_i = 32'h0F0F_0F0F;
    read_pair("no_false_bypass", 5'd3, 5'd7);
    reg_wena_i = 1'b0;

    // x0 is never written and never bypassed.
    reg_wena_i  = 1'b1;
    reg_waddr_i = 5'd0;
    reg_wdata_i = 32'hFFFF_FFFF;
    rs1_raddr_i = 5'd0;
    rs2_raddr_i = 5'd0;
    expect_rd("x0_pending_rs1", 0, 32'h0);
    expect_rd("x0_pending_rs2", 1, 32'h0);
`ifdef REGFILE_DEBUG_PORT_EN
    dbg_raddr_i = 5'd0;
    expect_rd("x0_pending_dbg", 2, 32'h0);
`endif
    settle();
    tick();
    reg_wena_i = 1'b0;
    $display("WR x0 <= ffffffff (discarded)");
    expect_rd("x0_after_rs2", 1, 32'h0);
    settle();
    tick();
    expect_rd("x0_later_rs2", 1, 32'h0);
    settle();

    // Read enable gating, including over a pending bypass.
    do_write(5'd9, 32'h1234_5678);
    rs1_rena_i  = 1'b0;
    rs1_raddr_i = 5'd9;
    rs2_raddr_i = 5'd9;
    expect_rd("rena0_rs1", 0, 32'h0);
    expect_rd("rena1_rs2", 1, 32'h1234_5678);
    settle();
    rs1_rena_i = 1'b1;
    expect_rd("rena_raise_rs1", 0, 32'h1234_5678);
    settle();
    rs1_rena_i  = 1'b0;
    reg_wena_i  = 1'b1;
    reg_waddr_i = 5'd9;
    reg_wdata_i = 32'h0BAD_F00D;
    expect_rd("rena0_bypass_rs1", 0, 32'h0);
    expect_rd("rena1_bypass_rs2", 1, 32'h0BAD_F00D);
    settle();
    tick();
    reg_wena_i = 1'b0;
    rs1_rena_i = 1'b1;
    model[9]   = 32'h0BAD_F00D;
    read_pair("rena_after_wr", 5'd9, 5'd9);
`ifdef REGFILE_DEBUG_PORT_EN
    expect_rd("wcnt_five", 3, 32'd5);
    settle();
`endif

    // Asynchronous reset pulse between edges clears storage immediately.
    do_write(5'd4, 32'hA5A5_A5A5);
    read_pair("x4_before_rst", 5'd4, 5'd3);
    arst_n = 1'b0;
    #1;
    expect_rd("midrst_rs1", 0, 32'h0);
    expect_rd("midrst_rs2", 1, 32'h0);
    settle();
    #3 arst_n = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = '0;
    read_pair("x4_after_rst", 5'd4, 5'd3);
`ifdef REGFILE_DEBUG_PORT_EN
    expect_rd("wcnt_midrst", 3, 32'd0);
    settle();
`endif

    do_write(5'd1, 32'h0000_0001);
    do_write(5'd0, 32'hFFFF_FFFF);
    do_write(5'd2, 32'h0000_0002);
    read_pair("post_rst_wr", 5'd1, 5'd2);
`ifdef REGFILE_DEBUG_PORT_EN
    expect_rd("wcnt_three_wr", 3, 32'd2);
    dbg_raddr_i = 5'd2;
    expect_rd("dbg_read_x2", 2, 32'h0000_0002);
    settle();
`endif

    for (int a = 0; a < 32; a++) read_pair("final_sweep", 5'(a), 5'(a ^ 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
